// File: rtl/fp_sqrt_pkg.sv
// fp_sqrt_pkg: shared state encoding, operand layout and constants for fp_sqrt_arbiter
package fp_sqrt_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } arb_state_t;

    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [6:0] frac;
    } fp16_t;

    localparam logic [15:0] FP16_ERR = 16'hFFFF;

    // Signed zero: exponent and fraction both clear, sign ignored
    function automatic logic fp16_is_zero(input fp16_t v);
        return (v.exp == 8'd0) && (v.frac == 7'd0);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// rr_picker: one-hot round-robin pick of the first request at or after the pointer
module rr_picker #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req_i,
    input  logic [$clog2(N_REQ)-1:0] ptr_i,
    output logic [N_REQ-1:0]         gnt_o,
    output logic [$clog2(N_REQ)-1:0] idx_o
);

    localparam int PW = $clog2(N_REQ);

    logic [PW-1:0] j;
    logic          found;

    // Walk the slots from the pointer with wrap-around; the first set request wins
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            j = PW'((int'(ptr_i) + i) % N_REQ);
            if (!found && req_i[j]) begin
                gnt_o[j] = 1'b1;
                idx_o    = j;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_sqrt_arbiter.sv
// fp_sqrt_arbiter: shares one floating_point_sqrt datapath between N_REQ requesters.
// Optional FP_SQRT_ARB_BYPASS_EN answers signed zero and negative operands without the datapath.
module fp_sqrt_arbiter
    import fp_sqrt_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int RST_CYC = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req_valid_i,
    input  logic [16*N_REQ-1:0] req_data_i,
    output logic [N_REQ-1:0]    req_ready_o,
    output logic [N_REQ-1:0]    resp_valid_o,
    input  logic [N_REQ-1:0]    resp_ready_i,
    output logic [15:0]         resp_data_o,
    output logic                resp_error_o,
    output logic                sqrt_rst_o,
    output logic                sqrt_start_o,
    output logic [15:0]         sqrt_num_o,
    input  logic [15:0]         sqrt_res_i,
    input  logic                sqrt_valid_i,
    input  logic                sqrt_error_i
);

    localparam int PW = $clog2(N_REQ);

    arb_state_t       state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [PW-1:0]    idx_q, idx_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    fp16_t            op_q, op_d;
    logic [15:0]      res_q, res_d;
    logic             err_q, err_d;
    logic [3:0]       rcnt_q, rcnt_d;
    logic [7:0]       tcnt_q, tcnt_d;

    logic [N_REQ-1:0] pick;
    logic [PW-1:0]    pick_idx;
    fp16_t            req_op;
    logic             timeout_hit;

    rr_picker #(.N_REQ(N_REQ)) u_pick (
        .req_i (req_valid_i),
        .ptr_i (ptr_q),
        .gnt_o (pick),
        .idx_o (pick_idx)
    );

    // Operand of the requester the picker selected this cycle
    always_comb begin
        req_op = '0;
        for (int i = 0; i < N_REQ; i++)
            if (pick[i]) req_op = req_data_i[16*i +: 16];
    end

    assign timeout_hit = (state_q == WAIT) && (tcnt_q == 8'(TIMEOUT - 1));

    // Sequencer: grant, clear the datapath, start it, wait for a result or timeout, hand back
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        op_d    = op_q;
        res_d   = res_q;
        err_d   = err_q;
        rcnt_d  = rcnt_q;
        tcnt_d  = tcnt_q;
        case (state_q)
            IDLE: begin
                if (|req_valid_i) begin
                    gnt_d   = pick;
                    idx_d   = pick_idx;
                    op_d    = req_op;
                    rcnt_d  = '0;
                    state_d = CLR;
`ifdef FP_SQRT_ARB_BYPASS_EN
                    if (fp16_is_zero(req_op)) begin
                        res_d   = req_op;
                        err_d   = 1'b0;
                        state_d = RESP;
                    end else if (req_op.sign) begin
                        res_d   = FP16_ERR;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
`endif
                end
            end
            CLR: begin
                if (rcnt_q == 4'(RST_CYC - 1)) state_d = ISSUE;
                else rcnt_d = rcnt_q + 4'd1;
            end
            ISSUE: begin
                tcnt_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (sqrt_valid_i) begin
                    res_d   = sqrt_res_i;
                    err_d   = sqrt_error_i;
                    state_d = RESP;
                end else if (timeout_hit) begin
                    res_d   = FP16_ERR;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                end
            end
            RESP: begin
                if (|(resp_ready_i & gnt_q)) begin
                    ptr_d   = (idx_q == PW'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; an asynchronous reset abandons any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            op_q    <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            rcnt_q  <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            op_q    <= op_d;
            res_q   <= res_d;
            err_q   <= err_d;
            rcnt_q  <= rcnt_d;
            tcnt_q  <= tcnt_d;
        end
    end

    assign req_ready_o  = (state_q == IDLE) ? pick : '0;
    assign resp_valid_o = (state_q == RESP) ? gnt_q : '0;
    assign resp_data_o  = (state_q == RESP) ? res_q : '0;
    assign resp_error_o = (state_q == RESP) && err_q;
    // Datapath held in reset with the arbiter, while clearing, and on the abort cycle
    assign sqrt_rst_o   = !rst_n || (state_q == CLR) || (timeout_hit && !sqrt_valid_i);
    assign sqrt_start_o = (state_q == ISSUE);
    assign sqrt_num_o   = op_q;

endmodule

// File: tb/tb_fp_sqrt_arbiter.sv
// tb_fp_sqrt_arbiter: scenario tasks against a stub datapath and a round-robin reference model
module tb_fp_sqrt_arbiter;

    localparam int N   = 4;
    localparam int RC  = 2;
    localparam int TO  = 64;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid_i = '0;
    logic [16*N-1:0] req_data_i = '0;
    logic [N-1:0]    req_ready_o;
    logic [N-1:0]    resp_valid_o;
    logic [N-1:0]    resp_ready_i = '0;
    logic [15:0]     resp_data_o;
    logic            resp_error_o;
    logic            sqrt_rst_o;
    logic            sqrt_start_o;
    logic [15:0]     sqrt_num_o;
    logic [15:0]     sqrt_res_i;
    logic            sqrt_valid_i;
    logic            sqrt_error_i;

    int checks = 0;
    int failures = 0;
    int m_ptr = 0;
    int stub_lat = 3;
    bit stub_dead = 1'b0;
    logic [15:0] data_a [N];

    fp_sqrt_arbiter #(.N_REQ(N), .RST_CYC(RC), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_data_o(resp_data_o), .resp_error_o(resp_error_o),
        .sqrt_rst_o(sqrt_rst_o), .sqrt_start_o(sqrt_start_o), .sqrt_num_o(sqrt_num_o),
        .sqrt_res_i(sqrt_res_i), .sqrt_valid_i(sqrt_valid_i), .sqrt_error_i(sqrt_error_i)
    );

    always #5 clk = ~clk;

    // Stub datapath: true roots for the known vectors, a reversible scramble otherwise
    function automatic logic [15:0] dp_res(input logic [15:0] op);
        if (op == 16'h0290) return 16'h0140;
        if (op == 16'h0248) return 16'h0120;
        return op ^ 16'h5A5A;
    endfunction

    // Expected {error, data} for an operand as seen by the requester
    function automatic logic [16:0] m_resp(input logic [15:0] op);
`ifdef FP_SQRT_ARB_BYPASS_EN
        if (op[14:0] == 15'd0) return {1'b0, op};
        if (op[15]) return {1'b1, 16'hFFFF};
`endif
        return {op[15], dp_res(op)};
    endfunction

    // Reference arbitration: first pending requester at or after the pointer
    function automatic int m_pick(input logic [N-1:0] pend);
        for (int i = 0; i < N; i++)
            if (pend[(m_ptr + i) % N]) return (m_ptr + i) % N;
        return -1;
    endfunction

    logic [15:0] s_op;
    int          s_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_cnt <= 0; s_op <= '0;
            sqrt_valid_i <= 1'b0; sqrt_res_i <= '0; sqrt_error_i <= 1'b0;
        end else begin
            sqrt_valid_i <= 1'b0;
            if (sqrt_rst_o) s_cnt <= 0;
            else if (sqrt_start_o) begin
                s_op  <= sqrt_num_o;
                s_cnt <= stub_dead ? 0 : stub_lat;
            end else if (s_cnt == 1) begin
                sqrt_valid_i <= 1'b1;
                sqrt_res_i   <= dp_res(s_op);
                sqrt_error_i <= s_op[15];
                s_cnt        <= 0;
            end else if (s_cnt > 1) s_cnt <= s_cnt - 1;
        end
    end

    task automatic set_req(input int i, input logic [15:0] d);
        data_a[i] = d;
        req_data_i[16*i +: 16] = d;
        req_valid_i[i] = 1'b1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; req_valid_i = '0; resp_ready_i = '0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        m_ptr = 0;
        @(negedge clk); #1;
    endtask

    // One full operation from grant to consumed response; observations only, no judging
    task automatic do_op(input bit hold, input bit wrong_rdy,
                         output int g, output int ridx, output logic [15:0] d, output logic e,
                         output int lat, output int n_rst, output int n_start,
                         output bit held, output bit ok);
        int cyc;
        logic [N-1:0] v;
        ok = 1'b0; g = -1; ridx = -1; d = '0; e = 1'b0; lat = 0;
        n_rst = 0; n_start = 0; held = 1'b1; cyc = 0;
        #1;
        while (req_ready_o == '0 && cyc < 300) begin @(negedge clk); #1; cyc++; end
        if (req_ready_o == '0) return;
        for (int i = 0; i < N; i++) if (req_ready_o[i]) g = i;
        do begin
            @(negedge clk); #1; lat++;
            if (lat == 1 && !hold) req_valid_i[g] = 1'b0;
            n_rst   += int'(sqrt_rst_o);
            n_start += int'(sqrt_start_o);
        end while (resp_valid_o == '0 && lat < 400);
        if (resp_valid_o == '0) return;
        for (int i = 0; i < N; i++) if (resp_valid_o[i]) ridx = i;
        d = resp_data_o; e = resp_error_o;
        if (wrong_rdy) begin
            v = resp_valid_o;
            resp_ready_i = ~v;
            repeat (2) begin @(negedge clk); #1; held &= (resp_valid_o == v) && (resp_data_o == d); end
        end
        resp_ready_i = resp_valid_o;
        @(negedge clk); #1;
        resp_ready_i = '0;
        ok = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk); #1;
        checks++; if (req_ready_o !== '0) begin failures++; $display("FAIL rst_req_ready got=%b exp=0", req_ready_o); end
        checks++; if (resp_valid_o !== '0) begin failures++; $display("FAIL rst_resp_valid got=%b exp=0", resp_valid_o); end
        checks++; if (resp_data_o !== 16'h0) begin failures++; $display("FAIL rst_resp_data got=%h exp=0000", resp_data_o); end
        checks++; if (resp_error_o !== 1'b0) begin failures++; $display("FAIL rst_resp_error got=%b exp=0", resp_error_o); end
        checks++; if (sqrt_rst_o !== 1'b1) begin failures++; $display("FAIL rst_sqrt_rst got=%b exp=1", sqrt_rst_o); end
        checks++; if (sqrt_start_o !== 1'b0) begin failures++; $display("FAIL rst_sqrt_start got=%b exp=0", sqrt_start_o); end
        checks++; if (sqrt_num_o !== 16'h0) begin failures++; $display("FAIL rst_sqrt_num got=%h exp=0000", sqrt_num_o); end
        rst_n = 1'b1; m_ptr = 0;
        @(negedge clk); #1;
        checks++; if (sqrt_rst_o !== 1'b0) begin failures++; $display("FAIL idle_sqrt_rst got=%b exp=0", sqrt_rst_o); end
        checks++; if (resp_valid_o !== '0) begin failures++; $display("FAIL idle_resp_valid got=%b exp=0", resp_valid_o); end
    endtask

    task automatic test_single();
        int g, ridx, lat, nr, ns; logic [15:0] d; logic e; bit held, ok;
        stub_lat = 3;
        set_req(0, 16'h0290);
        do_op(1'b0, 1'b1, g, ridx, d, e, lat, nr, ns, held, ok);
        checks++; if (!ok) begin failures++; $display("FAIL single_done got=timeout exp=response"); end
        checks++; if (g !== 0 || ridx !== 0) begin failures++; $display("FAIL single_index got=%0d/%0d exp=0/0", g, ridx); end
        checks++; if (d !== 16'h0140 || e !== 1'b0) begin failures++; $display("FAIL single_data got=%h/%b exp=0140/0", d, e); end
        checks++; if (nr !== RC) begin failures++; $display("FAIL single_rst_cycles got=%0d exp=%0d", nr, RC); end
        checks++; if (ns !== 1) begin failures++; $display("FAIL single_start_pulses got=%0d exp=1", ns); end
        checks++; if (lat !== RC + 2 + stub_lat + 1) begin failures++; $display("FAIL single_latency got=%0d exp=%0d", lat, RC + 3 + stub_lat); end
        checks++; if (!held) begin failures++; $display("FAIL single_foreign_ready got=dropped exp=held"); end
        m_ptr = 1;
    endtask

    task automatic test_simultaneous();
        int g, ridx, lat, nr, ns; logic [15:0] d; logic e; bit held, ok;
        apply_reset();
        set_req(0, 16'h0290);
        set_req(2, 16'h0248);
        do_op(1'b0, 1'b0, g, ridx, d, e, lat, nr, ns, held, ok);
        checks++; if (!ok || g !== 0 || ridx !== 0 || d !== 16'h0140 || e !== 1'b0)
            begin failures++; $display("FAIL simul_first got=g%0d r%0d %h/%b exp=g0 r0 0140/0", g, ridx, d, e); end
        do_op(1'b0, 1'b0, g, ridx, d, e, lat, nr, ns, held, ok);
        checks++; if (!ok || g !== 2 || ridx !== 2 || d !== 16'h0120 || e !== 1'b0)
            begin failures++; $display("FAIL simul_second got=g%0d r%0d %h/%b exp=g2 r2 0120/0", g, ridx, d, e); end
    endtask

    task automatic test_round_robin();
        int g, ridx, lat, nr, ns, exp_g; logic [15:0] d; logic e; bit held, ok;
        apply_reset();
        for (int i = 0; i < N; i++) set_req(i, 16'h0100 + 16'(i));
        for (int k = 0; k < 8; k++) begin
            exp_g = m_pick(req_valid_i);
            do_op(1'b1, 1'b0, g, ridx, d, e, lat, nr, ns, held, ok);
            checks++; if (!ok || g !== k % N || g !== exp_g || ridx !== g || {e, d} !== m_resp(data_a[exp_g]))
                begin failures++; $display("FAIL rr_op%0d got=g%0d r%0d %h exp=g%0d %h", k, g, ridx, d, k % N, m_resp(data_a[k % N])); end
            m_ptr = (exp_g + 1) % N;
        end
        req_valid_i = '0;
    endtask

    task automatic test_timeout();
        int g, ridx, lat, nr, ns, exp_g; logic [15:0] d; logic e; bit held, ok;
        stub_dead = 1'b1;
        set_req(1, 16'h0290);
        exp_g = m_pick(req_valid_i);
        do_op(1'b0, 1'b0, g, ridx, d, e, lat, nr, ns, held, ok);
        checks++; if (!ok || g !== exp_g || d !== 16'hFFFF || e !== 1'b1)
            begin failures++; $display("FAIL timeout_resp got=g%0d %h/%b exp=g%0d FFFF/1", g, d, e, exp_g); end
        checks++; if (nr !== RC + 1) begin failures++; $display("FAIL timeout_rst_pulse got=%0d exp=%0d", nr, RC + 1); end
        checks++; if (lat < RC + 1 + TO || lat > RC + 3 + TO) begin failures++; $display("FAIL timeout_latency got=%0d exp=%0d", lat, RC + 2 + TO); end
        m_ptr = (exp_g + 1) % N;
        stub_dead = 1'b0;
        set_req(3, 16'h0248);
        do_op(1'b0, 1'b0, g, ridx, d, e, lat, nr, ns, held, ok);
        checks++; if (!ok || g !== 3 || d !== 16'h0120 || e !== 1'b0)
            begin failures++; $display("FAIL timeout_recover got=g%0d %h/%b exp=g3 0120/0", g, d, e); end
        m_ptr = 0;
    endtask

    task automatic test_reset_mid();
        int cyc, seen, g, ridx, lat, nr, ns; logic [15:0] d; logic e; bit held, ok;
        stub_lat = 30;
        set_req(1, 16'h1234);
        cyc = 0;
        #1;
        while (!sqrt_start_o && cyc < 50) begin
            @(negedge clk); #1; cyc++;
            if (cyc == 1) req_valid_i[1] = 1'b0;
        end
        checks++; if (!sqrt_start_o) begin failures++; $display("FAIL midrst_start got=0 exp=1"); end
        repeat (3) @(negedge clk);
        rst_n = 1'b0; #1;
        checks++; if (sqrt_rst_o !== 1'b1 || sqrt_start_o !== 1'b0 || sqrt_num_o !== 16'h0 || req_ready_o !== '0 ||
                      resp_valid_o !== '0 || resp_data_o !== 16'h0 || resp_error_o !== 1'b0)
            begin failures++; $display("FAIL midrst_outputs got=rst%b st%b num%h rv%b rd%h re%b exp=rst1 st0 num0000 rv0 rd0000 re0",
                  sqrt_rst_o, sqrt_start_o, sqrt_num_o, resp_valid_o, resp_data_o, resp_error_o); end
        @(negedge clk); #1 rst_n = 1'b1; m_ptr = 0;
        seen = 0;
        repeat (40) begin @(negedge clk); #1; if (resp_valid_o != '0) seen++; end
        checks++; if (seen !== 0) begin failures++; $display("FAIL midrst_no_resp got=%0d exp=0", seen); end
        stub_lat = 2;
        set_req(1, 16'h1234);
        do_op(1'b0, 1'b0, g, ridx, d, e, lat, nr, ns, held, ok);
        checks++; if (!ok || g !== 1 || {e, d} !== m_resp(16'h1234))
            begin failures++; $display("FAIL midrst_rerequest got=g%0d %h exp=g1 %h", g, d, m_resp(16'h1234)); end
        m_ptr = 2;
    endtask

`ifdef FP_SQRT_ARB_BYPASS_EN
    task automatic test_bypass();
        int g, ridx, lat, nr, ns; logic [15:0] d; logic e; bit held, ok;
        set_req(2, 16'h8000);
        do_op(1'b0, 1'b0, g, ridx, d, e, lat, nr, ns, held, ok);
        checks++; if (!ok || d !== 16'h8000 || e !== 1'b0 || ns !== 0)
            begin failures++; $display("FAIL bypass_zero got=%h/%b starts=%0d exp=8000/0 starts=0", d, e, ns); end
        m_ptr = (g + 1) % N;
        set_req(2, 16'h8290);
        do_op(1'b0, 1'b0, g, ridx, d, e, lat, nr, ns, held, ok);
        checks++; if (!ok || d !== 16'hFFFF || e !== 1'b1 || ns !== 0)
            begin failures++; $display("FAIL bypass_neg got=%h/%b starts=%0d exp=FFFF/1 starts=0", d, e, ns); end
        m_ptr = (g + 1) % N;
    endtask
`endif

    task automatic test_random();
        int g, ridx, lat, nr, ns, exp_g; logic [15:0] d; logic e; bit held, ok;
        for (int k = 0; k < 16; k++) begin
            stub_lat = int'($urandom_range(1, 6));
            for (int i = 0; i < N; i++)
                if (!req_valid_i[i] && ($urandom_range(0, 1) == 1)) set_req(i, 16'($urandom));
            if (req_valid_i == '0) set_req(k % N, 16'($urandom));
            exp_g = m_pick(req_valid_i);
            do_op(1'b0, 1'b0, g, ridx, d, e, lat, nr, ns, held, ok);
            checks++; if (!ok || g !== exp_g || ridx !== exp_g || {e, d} !== m_resp(data_a[exp_g]))
                begin failures++; $display("FAIL rand_op%0d got=g%0d r%0d %b/%h exp=g%0d %h", k, g, ridx, e, d, exp_g, m_resp(data_a[exp_g])); end
            m_ptr = (exp_g + 1) % N;
        end
        req_valid_i = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_round_robin();
        test_timeout();
        test_reset_mid();
`ifdef FP_SQRT_ARB_BYPASS_EN
        test_bypass();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=stalled exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
